// File: rtl/instruction_sequencer_pkg.sv
// Shared types and constants for the instruction sequencer.
// Opcode sits in the top three bits of each instruction word.
package seq_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    EXEC = 1'b1
  } state_e;

  localparam int IW       = 9;
  localparam int MAX_STEP = 3;
  localparam int OP_HI    = 8;
  localparam int OP_LO    = 6;

  function automatic logic [IW-1:0] mk_instr(
    input logic [OP_HI-OP_LO:0] op,
    input logic [OP_LO-1:0]     arg
  );
    return {op, arg};
  endfunction

endpackage

// File: rtl/instruction_sequencer_if.sv
// Loader / control-unit bundle of the instruction sequencer.
// master drives loads, run and clear; slave is the sequencer.
interface instruction_sequencer_if #(
  parameter int DEPTH = 8
);
  localparam int LW = $clog2(DEPTH) + 1;

  logic                   run;
  logic                   load_valid;
  logic [seq_pkg::IW-1:0] load_data;
  logic                   load_ready;
  logic                   clear;
  logic [seq_pkg::IW-1:0] iin;
  logic [1:0]             count;
  logic                   busy;
  logic                   done;
  logic [LW-1:0]          level;
  logic                   step_overrun;

  modport master (
    output run, load_valid, load_data, clear,
    input  load_ready, iin, count, busy,
    input  done, level, step_overrun
  );

  modport slave (
    input  run, load_valid, load_data, clear,
    output load_ready, iin, count, busy,
    output done, level, step_overrun
  );
endinterface

// File: rtl/instruction_sequencer_fifo.sv
// Synchronous FIFO holding queued instruction words.
// A push is refused whenever full, even alongside a pop.
module sync_fifo #(
  parameter int DEPTH = 8,
  parameter int W     = 9
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     push,
  input  logic                     pop,
  input  logic [W-1:0]             wdata,
  output logic [W-1:0]             rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);
  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wp, rp;
  logic          do_push, do_pop;

  assign full    = level == (AW+1)'(DEPTH);
  assign empty   = level == '0;
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign rdata   = mem[rp];

  always_ff @(posedge clock) begin
    if (do_push) mem[wp] <= wdata;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      wp    <= '0;
      rp    <= '0;
      level <= '0;
    end else begin
      if (do_push) wp <= wp + AW'(1);
      if (do_pop)  rp <= rp + AW'(1);
      level <= level + (AW+1)'(do_push)
                     - (AW+1)'(do_pop);
    end
  end
endmodule

// File: rtl/instruction_sequencer.sv
// Issues queued instructions to the control unit with a step count,
// retiring on clear (or forcibly at the last step) with zero bubble.
module instruction_sequencer
  import seq_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic                  clock,
  input  logic                  resetn,
  instruction_sequencer_if.slave bus
);
  localparam int         LW   = $clog2(DEPTH) + 1;
  localparam logic [1:0] LAST = 2'(MAX_STEP);

  state_e        state;
  logic [IW-1:0] iin_q, head;
  logic [1:0]    count_q;
  logic          done_q, ovr_q;
  logic          empty, full;
  logic          pop, retire, forced;
  logic [LW-1:0] level;

  assign forced = (state == EXEC) & ~bus.clear
                & (count_q == LAST);
  assign retire = (state == EXEC)
                & (bus.clear | (count_q == LAST));
  assign pop    = bus.run & ~empty
                & ((state == IDLE) | retire);

  sync_fifo #(
    .DEPTH (DEPTH),
    .W     (IW)
  ) u_fifo (
    .clock (clock),
    .reset (resetn),
    .push  (bus.load_valid),
    .pop   (pop),
    .wdata (bus.load_data),
    .rdata (head),
    .full  (full),
    .empty (empty),
    .level (level)
  );

  assign bus.iin          = iin_q;
  assign bus.count        = count_q;
  assign bus.busy         = state == EXEC;
  assign bus.done         = done_q;
  assign bus.level        = level;
  assign bus.load_ready   = ~full;
  assign bus.step_overrun = ovr_q;

  always_ff @(posedge clock) begin
    if (resetn) begin
      state   <= IDLE;
      iin_q   <= '0;
      count_q <= '0;
      done_q  <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      done_q <= retire;
      if (forced) ovr_q <= 1'b1;
      unique case (state)
        IDLE: begin
          count_q <= '0;
          if (pop) begin
            iin_q <= head;
            state <= EXEC;
          end
        end
        EXEC: begin
          if (retire) begin
            count_q <= '0;
            if (pop) iin_q <= head;
            else     state <= IDLE;
          end else begin
            count_q <= count_q + 2'd1;
          end
        end
      endcase
    end
  end
endmodule

// File: tb/tb_instruction_sequencer.sv
// Randomized bench for instruction_sequencer against a queue-based
// model of the issue/step/retire rules.
module tb_instruction_sequencer;
  import seq_pkg::*;

  localparam int DEPTH = 8;

  logic clock = 1'b0;
  logic resetn = 1'b1;
  int   n_cmp = 0;
  int   n_bad = 0;

  instruction_sequencer_if #(.DEPTH(DEPTH)) bus();

  instruction_sequencer #(.DEPTH(DEPTH)) dut (
    .clock  (clock),
    .resetn (resetn),
    .bus    (bus)
  );

  always #5 clock = ~clock;

  logic [IW-1:0] q [$];
  logic [IW-1:0] m_iin;
  int            m_count;
  bit            m_busy, m_done, m_ovr;

  // Predict the post-edge outputs from the inputs about to be sampled.
  task automatic model_step();
    bit            was_empty, was_full, retire, issue;
    logic [IW-1:0] head;
    if (resetn) begin
      q.delete();
      m_iin = '0; m_count = 0;
      m_busy = 0; m_done = 0; m_ovr = 0;
      return;
    end
    was_empty = q.size() == 0;
    was_full  = q.size() == DEPTH;
    head      = was_empty ? '0 : q[0];
    retire = m_busy && (bus.clear || m_count == MAX_STEP);
    if (m_busy && !bus.clear && m_count == MAX_STEP) m_ovr = 1;
    issue = bus.run && !was_empty && (!m_busy || retire);
    if (issue) void'(q.pop_front());
    if (bus.load_valid && !was_full) q.push_back(bus.load_data);
    m_done = retire;
    if (issue) begin
      m_iin = head; m_count = 0; m_busy = 1;
    end else if (retire) begin
      m_count = 0; m_busy = 0;
    end else if (m_busy) begin
      m_count++;
    end
  endtask

  task automatic tick();
    model_step();
    @(posedge clock);
    #1;
  endtask

  task automatic apply_reset();
    bus.run = 0; bus.load_valid = 0;
    bus.clear = 0; bus.load_data = '0;
    resetn = 1;
    tick();
    resetn = 0;
  endtask

  function automatic logic [18:0] dut_vec();
    return {bus.iin, bus.count, bus.busy, bus.done,
            bus.level, bus.load_ready, bus.step_overrun};
  endfunction

  function automatic logic [18:0] mdl_vec();
    return {m_iin, 2'(m_count), m_busy, m_done,
            4'(q.size()), q.size() < DEPTH, m_ovr};
  endfunction

  function automatic logic [IW-1:0] rnd_instr();
    return mk_instr(3'($urandom), 6'($urandom));
  endfunction

  task automatic test_reset();
    apply_reset();
    n_cmp++;
    if (dut_vec() !== {9'h0, 2'd0, 1'b0, 1'b0, 4'd0, 1'b1, 1'b0}) begin
      n_bad++;
      $display("FAIL reset_state got %h exp %h", dut_vec(),
               {9'h0, 2'd0, 1'b0, 1'b0, 4'd0, 1'b1, 1'b0});
    end
  endtask

  task automatic test_back_to_back();
    logic [1:0] seq [$];
    int dones = 0;
    apply_reset();
    bus.load_valid = 1;
    bus.load_data = 9'h048; tick();
    bus.load_data = 9'h0C1; tick();
    bus.load_valid = 0;
    n_cmp++;
    if (bus.level !== 4'd2 || bus.busy !== 1'b0) begin
      n_bad++;
      $display("FAIL load_two got level=%0d busy=%b exp 2/0",
               bus.level, bus.busy);
    end
    bus.run = 1; tick();
    n_cmp++;
    if (bus.iin !== 9'h048 || bus.count !== 2'd0 || bus.busy !== 1'b1) begin
      n_bad++;
      $display("FAIL first_issue got iin=%h cnt=%0d busy=%b exp 048/0/1",
               bus.iin, bus.count, bus.busy);
    end
    for (int i = 0; i < 6; i++) begin
      if (bus.busy === 1'b1) seq.push_back(bus.count);
      bus.clear = m_busy && m_count == 1;
      tick();
      if (bus.done === 1'b1) dones++;
      n_cmp++;
      if (dut_vec() !== mdl_vec()) begin
        n_bad++;
        $display("FAIL b2b_cycle%0d got %h exp %h", i, dut_vec(), mdl_vec());
      end
    end
    bus.clear = 0;
    n_cmp++;
    if (seq.size() != 4 || seq[0] !== 2'd0 || seq[1] !== 2'd1
        || seq[2] !== 2'd0 || seq[3] !== 2'd1 || dones != 2) begin
      n_bad++;
      $display("FAIL b2b_counts got %0d steps %0d dones exp 4 steps 2 dones",
               seq.size(), dones);
    end
    n_cmp++;
    if (bus.busy !== 1'b0 || bus.level !== 4'd0 || bus.iin !== 9'h0C1) begin
      n_bad++;
      $display("FAIL b2b_end got busy=%b level=%0d iin=%h exp 0/0/0c1",
               bus.busy, bus.level, bus.iin);
    end
  endtask

  task automatic test_full();
    logic [IW-1:0] first;
    apply_reset();
    bus.load_valid = 1;
    for (int i = 0; i < DEPTH; i++) begin
      bus.load_data = rnd_instr();
      if (i == 0) first = bus.load_data;
      tick();
    end
    n_cmp++;
    if (bus.load_ready !== 1'b0 || bus.level !== 4'd8) begin
      n_bad++;
      $display("FAIL full got ready=%b level=%0d exp 0/8",
               bus.load_ready, bus.level);
    end
    bus.load_data = 9'h1FF; tick();
    n_cmp++;
    if (bus.level !== 4'd8 || dut_vec() !== mdl_vec()) begin
      n_bad++;
      $display("FAIL ninth_load got %h exp %h", dut_vec(), mdl_vec());
    end
    bus.run = 1; bus.load_data = 9'h155; tick();
    bus.load_valid = 0;
    n_cmp++;
    if (bus.level !== 4'd7 || bus.iin !== first || bus.busy !== 1'b1) begin
      n_bad++;
      $display("FAIL pop_push_full got level=%0d iin=%h exp 7/%h",
               bus.level, bus.iin, first);
    end
    bus.clear = 1;
    for (int i = 0; i < 10; i++) begin
      tick();
      n_cmp++;
      if (dut_vec() !== mdl_vec()) begin
        n_bad++;
        $display("FAIL drain%0d got %h exp %h", i, dut_vec(), mdl_vec());
      end
    end
    bus.clear = 0;
  endtask

  task automatic test_overrun();
    logic [1:0] cs [$];
    apply_reset();
    bus.load_valid = 1; bus.load_data = rnd_instr(); tick();
    bus.load_valid = 0; bus.run = 1; tick();
    for (int i = 0; i < 4; i++) begin
      cs.push_back(bus.count);
      tick();
    end
    n_cmp++;
    if (cs[0] !== 2'd0 || cs[1] !== 2'd1 || cs[2] !== 2'd2 || cs[3] !== 2'd3) begin
      n_bad++;
      $display("FAIL overrun_steps got %0d%0d%0d%0d exp 0123",
               cs[0], cs[1], cs[2], cs[3]);
    end
    n_cmp++;
    if (bus.done !== 1'b1 || bus.step_overrun !== 1'b1 || bus.busy !== 1'b0) begin
      n_bad++;
      $display("FAIL forced_retire got done=%b ovr=%b busy=%b exp 1/1/0",
               bus.done, bus.step_overrun, bus.busy);
    end
    bus.load_valid = 1;
    bus.load_data = rnd_instr(); tick();
    bus.load_data = rnd_instr(); tick();
    bus.load_valid = 0; bus.clear = 1;
    for (int i = 0; i < 4; i++) begin
      tick();
      n_cmp++;
      if (dut_vec() !== mdl_vec() || bus.step_overrun !== 1'b1) begin
        n_bad++;
        $display("FAIL sticky%0d got %h exp %h", i, dut_vec(), mdl_vec());
      end
    end
    bus.clear = 0;
  endtask

  task automatic test_reset_mid();
    apply_reset();
    bus.load_valid = 1;
    for (int i = 0; i < 6; i++) begin
      bus.load_data = rnd_instr(); tick();
    end
    bus.load_valid = 0; bus.run = 1; tick();
    tick(); tick();
    n_cmp++;
    if (bus.count !== 2'd2 || bus.level !== 4'd5 || bus.busy !== 1'b1) begin
      n_bad++;
      $display("FAIL pre_reset got cnt=%0d level=%0d exp 2/5",
               bus.count, bus.level);
    end
    resetn = 1; tick(); resetn = 0;
    n_cmp++;
    if (bus.busy !== 1'b0 || bus.count !== 2'd0 || bus.level !== 4'd0
        || bus.iin !== 9'h0 || bus.done !== 1'b0) begin
      n_bad++;
      $display("FAIL reset_mid got %h exp busy/cnt/level/iin/done 0",
               dut_vec());
    end
    bus.run = 0;
  endtask

  task automatic test_run_drop();
    apply_reset();
    bus.load_valid = 1;
    for (int i = 0; i < 4; i++) begin
      bus.load_data = rnd_instr(); tick();
    end
    bus.load_valid = 0; bus.run = 1; tick();
    tick();
    bus.run = 0; bus.clear = 1; tick();
    n_cmp++;
    if (bus.done !== 1'b1 || bus.busy !== 1'b0 || bus.level !== 4'd3) begin
      n_bad++;
      $display("FAIL run_drop got done=%b busy=%b level=%0d exp 1/0/3",
               bus.done, bus.busy, bus.level);
    end
    bus.clear = 0; tick();
    n_cmp++;
    if (bus.done !== 1'b0 || bus.busy !== 1'b0 || bus.level !== 4'd3) begin
      n_bad++;
      $display("FAIL run_drop_idle got done=%b busy=%b level=%0d exp 0/0/3",
               bus.done, bus.busy, bus.level);
    end
  endtask

  task automatic test_random();
    apply_reset();
    for (int i = 0; i < 400; i++) begin
      resetn         = $urandom_range(0, 99) == 0;
      bus.run        = $urandom_range(0, 3) != 0;
      bus.load_valid = $urandom_range(0, 1) == 1;
      bus.load_data  = rnd_instr();
      bus.clear      = $urandom_range(0, 2) == 0;
      tick();
      n_cmp++;
      if (dut_vec() !== mdl_vec()) begin
        n_bad++;
        $display("FAIL random%0d got %h exp %h", i, dut_vec(), mdl_vec());
      end
    end
    resetn = 0;
  endtask

  initial begin
    test_reset();
    test_back_to_back();
    test_full();
    test_overrun();
    test_reset_mid();
    test_run_drop();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
